// File: rtl/weight_shadow_bank.sv
// -----------------------------------------------------------------------------
// weight_shadow_bank
//
// Double-buffered weight store that sits between the weight flow controller
// and the systolic matrix multiply unit. Incoming weight rows are collected in
// a shadow bank. Once every row of a MATRIX_WIDTH x MATRIX_WIDTH tile is
// present, an activate request copies the shadow tile into the active bank
// that drives the MMU. The next tile can then preload while the current one
// computes. Each row is widened to BYTE_WIDTH+1 bits during the copy, using
// sign or zero extension according to the signedness captured with that row.
//
// Ports
//   clk              : single clock; all state updates on the rising edge
//   rst              : asynchronous, active-low reset
//   enable           : global stall; when low, every register holds and
//                      every input is ignored
//   load_weight      : weight_data carries a valid row this cycle
//   weight_addr      : target row index; all bits are range-checked
//   weight_data      : one row; column c is at [c*BYTE_WIDTH +: BYTE_WIDTH]
//   is_weight_signed : signedness of the row on weight_data
//   activate         : request to swap the shadow tile into the active bank
//   active_weights   : active tile; element (r,c) is at
//                      [(r*MATRIX_WIDTH+c)*(BYTE_WIDTH+1) +: BYTE_WIDTH+1]
//   active_valid     : the active bank holds a swapped-in tile
//   shadow_full      : every shadow row has been written
//   swap_done        : one-cycle pulse in the cycle after a swap edge
//   load_error       : one-cycle pulse after a dropped load
// -----------------------------------------------------------------------------
module weight_shadow_bank #(
  parameter int MATRIX_WIDTH = 14,
  parameter int BYTE_WIDTH   = 8
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               enable,
  input  logic                                               load_weight,
  input  logic [BYTE_WIDTH-1:0]                              weight_addr,
  input  logic [MATRIX_WIDTH*BYTE_WIDTH-1:0]                 weight_data,
  input  logic                                               is_weight_signed,
  input  logic                                               activate,
  output logic [MATRIX_WIDTH*MATRIX_WIDTH*(BYTE_WIDTH+1)-1:0] active_weights,
  output logic                                               active_valid,
  output logic                                               shadow_full,
  output logic                                               swap_done,
  output logic                                               load_error
);

  localparam int EXT_W = BYTE_WIDTH + 1;
  localparam int ROW_W = MATRIX_WIDTH * BYTE_WIDTH;
  localparam int IDX_W = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;
  localparam int TILE_W = MATRIX_WIDTH * MATRIX_WIDTH * EXT_W;

  // Row count expressed at the address width, so the range check covers
  // every address bit rather than only the low index bits.
  localparam logic [BYTE_WIDTH-1:0] ROW_LIMIT = BYTE_WIDTH'(MATRIX_WIDTH);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } shadow_state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  shadow_state_e           state_q;
  shadow_state_e           state_d;
  logic [MATRIX_WIDTH-1:0] row_mask_q;
  logic [MATRIX_WIDTH-1:0] row_mask_d;
  logic                    activate_pending_q;
  logic                    activate_pending_d;

  logic [ROW_W-1:0]        shadow_data_q [MATRIX_WIDTH];
  logic [MATRIX_WIDTH-1:0] shadow_signed_q;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic             addr_in_range;
  logic [IDX_W-1:0] row_idx;
  logic             load_accept;
  logic             load_drop;
  logic             swap_fire;
  logic [TILE_W-1:0] swap_tile;

  assign addr_in_range = (weight_addr < ROW_LIMIT);
  assign row_idx       = weight_addr[IDX_W-1:0];

  // A load landing on a full bank is dropped rather than back-pressured. The
  // upstream controller is expected never to do this, so it is only flagged.
  assign load_accept = enable && load_weight && addr_in_range && (state_q != FULL);
  assign load_drop   = enable && load_weight && (!addr_in_range || (state_q == FULL));

  // A swap needs FULL, and FULL drops every load. A swap and a shadow write
  // therefore never share an edge.
  assign swap_fire = enable && (state_q == FULL) && (activate || activate_pending_q);

  assign shadow_full = (state_q == FULL);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned in this block gets a default first, so no
    // path through the block leaves a value unassigned and no latch is inferred.
    row_mask_d         = row_mask_q;
    activate_pending_d = activate_pending_q;
    state_d            = state_q;

    if (swap_fire) begin
      row_mask_d         = '0;
      activate_pending_d = 1'b0;
    end else begin
      if (load_accept) begin
        row_mask_d[row_idx] = 1'b1;
      end
      // A request that arrives before the tile is complete is remembered. The
      // swap then happens on the first enabled edge that sees FULL.
      if (enable && activate) begin
        activate_pending_d = 1'b1;
      end
    end

    // The FSM state is a registered summary of the row mask. It is kept as
    // its own register so that shadow_full is driven straight from a flop.
    if (row_mask_d == '0) begin
      state_d = EMPTY;
    end else if (row_mask_d == '1) begin
      state_d = FULL;
    end else begin
      state_d = FILLING;
    end
  end

  // Widen each shadow row into active-bank format. Signed rows replicate the
  // element MSB into the extra bit; unsigned rows put zero there.
  always_comb begin
    swap_tile = '0;
    for (int r = 0; r < MATRIX_WIDTH; r++) begin
      for (int c = 0; c < MATRIX_WIDTH; c++) begin
        swap_tile[(r*MATRIX_WIDTH+c)*EXT_W +: EXT_W] =
          {shadow_signed_q[r] & shadow_data_q[r][c*BYTE_WIDTH+BYTE_WIDTH-1],
           shadow_data_q[r][c*BYTE_WIDTH +: BYTE_WIDTH]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge, whatever order the statements run in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= EMPTY;
      row_mask_q         <= '0;
      activate_pending_q <= 1'b0;
      swap_done          <= 1'b0;
      load_error         <= 1'b0;
    end else begin
      // With enable low, the next-state terms equal the current state.
      state_q            <= state_d;
      row_mask_q         <= row_mask_d;
      activate_pending_q <= activate_pending_d;
      // The status pulses hold through a stall instead of clearing or
      // re-pulsing. They are therefore updated only on enabled edges.
      if (enable) begin
        swap_done  <= swap_fire;
        load_error <= load_drop;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow bank
  // ---------------------------------------------------------------------------
  // NOTE: the shadow rows are explicitly cleared by reset. This keeps
  // discarded tile contents from surviving a reset, at the price of a reset
  // net on every shadow flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < MATRIX_WIDTH; r++) begin
        shadow_data_q[r] <= '0;
      end
      shadow_signed_q <= '0;
    end else if (load_accept) begin
      // Rewriting a row that is already present replaces its data and flag.
      // Its mask bit is set already, so the mask does not change.
      shadow_data_q[row_idx]   <= weight_data;
      shadow_signed_q[row_idx] <= is_weight_signed;
    end
  end

  // ---------------------------------------------------------------------------
  // Active bank: driven straight from flops, with no input-to-output path
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_weights <= '0;
      active_valid   <= 1'b0;
    end else if (swap_fire) begin
      active_weights <= swap_tile;
      active_valid   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_weight_shadow_bank.sv
// -----------------------------------------------------------------------------
// tb_weight_shadow_bank
//
// Directed bench for weight_shadow_bank. A table of vectors drives the first
// full load/swap sequence, including dropped loads. Hand-written sequences
// cover signed extension, early activate, stall and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_weight_shadow_bank;

  localparam int MW = 14;
  localparam int BW = 8;
  localparam int EW = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic              load_weight = 1'b0;
  logic [BW-1:0]     weight_addr = '0;
  logic [MW*BW-1:0]  weight_data = '0;
  logic              is_weight_signed = 1'b0;
  logic              activate = 1'b0;
  logic [MW*MW*EW-1:0] active_weights;
  logic              active_valid;
  logic              shadow_full;
  logic              swap_done;
  logic              load_error;

  int n_checks = 0;
  int n_errors = 0;

  weight_shadow_bank #(.MATRIX_WIDTH(MW), .BYTE_WIDTH(BW)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .load_weight      (load_weight),
    .weight_addr      (weight_addr),
    .weight_data      (weight_data),
    .is_weight_signed (is_weight_signed),
    .activate         (activate),
    .active_weights   (active_weights),
    .active_valid     (active_valid),
    .shadow_full      (shadow_full),
    .swap_done        (swap_done),
    .load_error       (load_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       ld;
    logic [7:0] addr;
    logic [7:0] dbyte;
    logic       sgn;
    logic       act;
    logic       exp_full;
    logic       exp_swap;
    logic       exp_err;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic en, ld, input logic [7:0] addr, dbyte,
                                  input logic sgn, act, exp_full, exp_swap, exp_err,
                                  exp_valid);
    vec_t v;
    v.en = en; v.ld = ld; v.addr = addr; v.dbyte = dbyte; v.sgn = sgn; v.act = act;
    v.exp_full = exp_full; v.exp_swap = exp_swap; v.exp_err = exp_err;
    v.exp_valid = exp_valid;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Applies the inputs after the previous edge, then waits for one rising
  // edge and returns 1 time unit later, where outputs are sampled.
  task automatic step(input logic en, ld, input logic [7:0] addr, dbyte,
                      input logic sgn, act);
    enable           = en;
    load_weight      = ld;
    weight_addr      = addr;
    weight_data      = {MW{dbyte}};
    is_weight_signed = sgn;
    activate         = act;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_flags(input string tag, input logic full, swp, err, valid);
    check($sformatf("%s.shadow_full", tag), 32'(shadow_full), 32'(full));
    check($sformatf("%s.swap_done", tag), 32'(swap_done), 32'(swp));
    check($sformatf("%s.load_error", tag), 32'(load_error), 32'(err));
    check($sformatf("%s.active_valid", tag), 32'(active_valid), 32'(valid));
  endtask

  task automatic check_row(input string tag, input int r, input logic [8:0] exp);
    logic [8:0] got;
    for (int c = 0; c < MW; c++) begin
      got = active_weights[(r*MW+c)*EW +: EW];
      check($sformatf("%s.row%0d.col%0d", tag, r, c), 32'(got), 32'(exp));
    end
  endtask

  // Unsigned loads of rows first..last with data base+r. shadow_full must
  // stay low until the last row, then equal full_at_end.
  task automatic fill_rows(input string tag, input int first, last,
                           input logic [7:0] base, input logic full_at_end);
    for (int r = first; r <= last; r++) begin
      step(1'b1, 1'b1, 8'(r), 8'(base + r), 1'b0, 1'b0);
      check($sformatf("%s.full_after_row%0d", tag, r), 32'(shadow_full),
            (r == last) ? 32'(full_at_end) : 32'd0);
    end
  endtask

  initial begin
    // -------------------------------------------------------------------------
    // Vector table for the first fill/swap sequence
    // -------------------------------------------------------------------------
    //       en  ld  addr   data   sgn act  full swp err valid
    add_vec(1, 0, 8'd0,  8'h00, 0, 0,   0,   0,  0,  0);
    add_vec(1, 1, 8'd14, 8'h55, 0, 0,   0,   0,  1,  0);   // out of range
    for (int r = 0; r <= 3; r++)
      add_vec(1, 1, 8'(r), 8'(r + 1), 0, 0, 0, 0, 0, 0);
    add_vec(1, 1, 8'h83, 8'hAA, 1, 0,   0,   0,  1,  0);   // high bits set
    for (int r = 4; r <= 13; r++)
      add_vec(1, 1, 8'(r), 8'(r + 1), 0, 0, (r == 13), 0, 0, 0);
    add_vec(1, 1, 8'd5,  8'h77, 0, 0,   1,   0,  1,  0);   // load while FULL
    add_vec(1, 0, 8'd0,  8'h00, 0, 1,   0,   1,  0,  1);   // swap edge
    add_vec(1, 0, 8'd0,  8'h00, 0, 0,   0,   0,  0,  1);

    // -------------------------------------------------------------------------
    // Reset state
    // -------------------------------------------------------------------------
    repeat (2) @(posedge clk);
    #1;
    check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.active_zero", 32'(active_weights == '0), 32'd1);
    rst = 1'b1;

    // -------------------------------------------------------------------------
    // Scenario 1: table-driven fill, dropped loads, swap
    // -------------------------------------------------------------------------
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].ld, vecs[i].addr, vecs[i].dbyte, vecs[i].sgn, vecs[i].act);
      check_flags($sformatf("vec%0d", i), vecs[i].exp_full, vecs[i].exp_swap,
                  vecs[i].exp_err, vecs[i].exp_valid);
    end
    check_row("s1", 0, 9'h001);
    check_row("s1", 3, 9'h004);   // 0x83 load was dropped
    check_row("s1", 5, 9'h006);   // load while FULL was dropped
    check_row("s1", 13, 9'h00E);

    // -------------------------------------------------------------------------
    // Scenario 2: signed vs unsigned extension
    // -------------------------------------------------------------------------
    for (int r = 0; r < MW; r++) begin
      if (r == 2)      step(1'b1, 1'b1, 8'(r), 8'h70, 1'b1, 1'b0);
      else if (r == 3) step(1'b1, 1'b1, 8'(r), 8'hF0, 1'b1, 1'b0);
      else if (r == 4) step(1'b1, 1'b1, 8'(r), 8'hF0, 1'b0, 1'b0);
      else             step(1'b1, 1'b1, 8'(r), 8'h81, 1'b0, 1'b0);
    end
    check_flags("s2.full", 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'd0, 8'h00, 1'b0, 1'b1);
    check_flags("s2.swap", 1'b0, 1'b1, 1'b0, 1'b1);
    check_row("s2", 2, 9'h070);
    check_row("s2", 3, 9'h1F0);
    check_row("s2", 4, 9'h0F0);
    check_row("s2", 0, 9'h081);
    idle();
    check_flags("s2.after", 1'b0, 1'b0, 1'b0, 1'b1);

    // -------------------------------------------------------------------------
    // Scenario 3: activate before FULL, repeated activate while pending
    // -------------------------------------------------------------------------
    fill_rows("s3a", 0, 6, 8'h10, 1'b0);
    step(1'b1, 1'b0, 8'd0, 8'h00, 1'b0, 1'b1);
    check_flags("s3.early_act", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int r = 7; r <= 13; r++) begin
      step(1'b1, 1'b1, 8'(r), 8'(8'h10 + r), 1'b0, (r == 9));
      check($sformatf("s3.full_row%0d", r), 32'(shadow_full), (r == 13) ? 32'd1 : 32'd0);
      check($sformatf("s3.noswap_row%0d", r), 32'(swap_done), 32'd0);
    end
    idle();
    check_flags("s3.swap", 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle();
      check_flags($sformatf("s3.quiet%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check_row("s3", 0, 9'h010);
    check_row("s3", 7, 9'h017);

    // -------------------------------------------------------------------------
    // Scenario 4: stall with loads and activate driven
    // -------------------------------------------------------------------------
    fill_rows("s4a", 0, 4, 8'h20, 1'b0);
    step(1'b1, 1'b1, 8'hF3, 8'h99, 1'b0, 1'b0);
    check_flags("s4.bad_addr", 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'd13, 8'hEE, 1'b1, 1'b1);
      check_flags($sformatf("s4.stall%0d", i), 1'b0, 1'b0, 1'b1, 1'b1);
    end
    idle();
    check_flags("s4.resume", 1'b0, 1'b0, 1'b0, 1'b1);
    // A stalled write to row 13 would make the bank full after row 12.
    fill_rows("s4b", 5, 12, 8'h20, 1'b0);
    fill_rows("s4c", 13, 13, 8'h20, 1'b1);
    idle();
    check_flags("s4.no_pending", 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'd0, 8'h00, 1'b0, 1'b1);
    check_flags("s4.swap", 1'b0, 1'b1, 1'b0, 1'b1);
    check_row("s4", 13, 9'h02D);
    check_row("s4", 4, 9'h024);

    // -------------------------------------------------------------------------
    // Scenario 5: async reset mid-fill, then a clean refill
    // -------------------------------------------------------------------------
    fill_rows("s5a", 0, 6, 8'h30, 1'b0);
    rst = 1'b0;
    #1;
    check_flags("s5.in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("s5.active_zero", 32'(active_weights == '0), 32'd1);
    #1;
    rst = 1'b1;
    fill_rows("s5b", 0, 12, 8'h01, 1'b0);
    step(1'b1, 1'b1, 8'd13, 8'h0E, 1'b0, 1'b1);   // last row plus activate
    check_flags("s5.last_row_act", 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    check_flags("s5.swap", 1'b0, 1'b1, 1'b0, 1'b1);
    check_row("s5", 5, 9'h006);
    check_row("s5", 13, 9'h00E);
    idle();
    check_flags("s5.after", 1'b0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/weight_shadow_bank.md
# weight_shadow_bank

Double-buffered weight store between the weight flow controller and the systolic matrix multiply unit. It captures weight rows as they arrive from the weight buffer under `load_weight`/`weight_addr` and assembles a full MATRIX_WIDTH×MATRIX_WIDTH tile in a shadow bank. On request it swaps the shadow tile into the active bank that drives the MMU, so the next tile can preload while the current one computes. Each row is sign- or zero-extended to 9 bits according to its captured signedness.

## Interface
- `MATRIX_WIDTH`, 14: rows and columns per weight tile.
- `BYTE_WIDTH`, 8: weight element width.
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `enable` in 1: global stall. When 0, every register holds and every input is ignored.
- `load_weight` in 1: the row on `weight_data` is valid this cycle.
- `weight_addr` in BYTE_WIDTH: target row index, 0..MATRIX_WIDTH-1.
- `weight_data` in MATRIX_WIDTH*BYTE_WIDTH: one row; column c is at `[c*8 +: 8]`.
- `is_weight_signed` in 1: signedness of the row on `weight_data`, sampled with `load_weight`.
- `activate` in 1: request to swap the shadow bank into the active bank.
- `active_weights` out MATRIX_WIDTH*MATRIX_WIDTH*9: active tile; row r, column c is at `[(r*MATRIX_WIDTH+c)*9 +: 9]`.
- `active_valid` out 1: the active bank holds a swapped-in tile.
- `shadow_full` out 1: all MATRIX_WIDTH shadow rows have been written.
- `swap_done` out 1: single-cycle pulse, high in the cycle after a swap edge.
- `load_error` out 1: single-cycle pulse flagging a dropped load.

## Operation
- Shadow state per row:
  - 8-bit data row.
  - 1-bit signed flag.
  - Valid bit, collected in `row_mask[MATRIX_WIDTH-1:0]`.
- Shadow FSM states:
  - EMPTY: `row_mask` is 0.
  - FILLING: `row_mask` is nonzero and not all-ones.
  - FULL: `row_mask` is all-ones; `shadow_full` is 1.
- Accepted load, when `enable && load_weight && weight_addr < MATRIX_WIDTH` and the state is not FULL:
  - Write the row data and signed flag.
  - Set `row_mask[weight_addr]`.
  - Rewriting a row already set in FILLING overwrites the data and flag; the mask is unchanged.
- Dropped load: the row is not written and `load_error` pulses. A load is dropped when either:
  - `weight_addr >= MATRIX_WIDTH`; bits above the index width are still compared.
  - The load arrives in FULL.
- `activate_pending` flag:
  - Set by `enable && activate` in any state.
  - Cleared by a swap.
  - Repeated `activate` while pending has no additional effect.
- Swap fires on a rising edge when `enable` is 1, the state is FULL, and either `activate` or `activate_pending` is 1. At that edge:
  - The active bank is loaded from the shadow rows, extended per row: signed replicates bit 7 into bit 8; unsigned puts 0 in bit 8.
  - `active_valid` is set to 1 and stays 1 until reset.
  - `row_mask` is cleared, so the state returns to EMPTY.
  - `activate_pending` is cleared.
  - `swap_done` is registered high for the following cycle.
- A load and a swap on the same edge cannot occur, because a swap needs FULL and loads in FULL are dropped with `load_error`.
- The last-row load and `activate` may arrive in the same cycle:
  - The row is written and `activate_pending` is set.
  - The swap fires on the next enabled edge.
- During a stall (`enable`=0), `swap_done` and `load_error` hold their value and are not re-pulsed.

## Timing
- Reset, asynchronous and active-low:
  - `active_weights` = 0, `active_valid` = 0, `shadow_full` = 0, `swap_done` = 0, `load_error` = 0.
  - `row_mask` = 0 and `activate_pending` = 0.
  - Shadow data = 0.
- Reset asserted mid-fill or mid-swap discards everything immediately; there is no partial swap.
- Load latency: `shadow_full` rises the cycle after the edge that writes the final missing row.
- Swap latency:
  - `activate` in FULL: the swap is at that edge; `active_weights` is new and `swap_done` is 1 in the next cycle.
  - `activate` before FULL: the swap is at the first enabled edge where FULL is registered.
- `load_error` is high for the one cycle after the offending edge.
- `active_weights` is driven directly from registers, with no combinational path from the inputs.
- There is no backpressure on `load_weight`. The upstream controller must not overrun a FULL bank; overrun is only flagged.

## Test plan
- Fill rows 0..13 in order with row r = r+1, unsigned, then pulse `activate` → `shadow_full`=1 one cycle after row 13; the swap follows, then `swap_done` pulses once. `active_weights` row 5 = 9'h006 in every column, `active_valid`=1, `shadow_full`=0.
- Signed row 3 = 8'hF0, unsigned row 4 = 8'hF0, fill, activate → row 3 reads 9'h1F0 and row 4 reads 9'h0F0.
- `activate` after row 6, then finish rows 7..13 → the swap fires at the first enabled edge after FULL is registered; `swap_done` pulses once; a second `activate` during filling gives no extra swap.
- Load with `weight_addr`=14, and a load while FULL → `load_error` pulses each time; `row_mask` and data are unchanged.
- Hold `enable`=0 for 5 cycles during filling, with loads and `activate` driven → no state change. Assert `rst` low mid-fill → all outputs 0 immediately; the next full fill behaves as in the first scenario.
